axi_pwm_custom_multi: RTL and testbench

// - Parametrised N-channel PWM generator; next generation of the fixed 6x12-bit LED PWM interface.
// - Adds programmable period, per-channel output polarity, edge- or center-aligned counting,
//   and a req/ack shadow-register update committed only at period boundaries.
// - Sits between the AXI register bank (pwm_clk domain) and the board LED/motor pins.

---
 rtl/axi_pwm_custom_multi.sv | 169 ++++++++++++++++
 tb/tb_axi_pwm_custom_multi.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_pwm_custom_multi.sv
// N-channel PWM generator: programmable period, per-channel polarity, edge/center counting and
// req/ack shadow registers committed at period boundaries. Optional phase offset: PWM_PHASE_OFFSET_EN.
module axi_pwm_custom_multi #(
    parameter int unsigned NUM_CH = 6,
    parameter int unsigned WIDTH  = 12
) (
    input  logic                    pwm_clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [WIDTH-1:0]        cfg_period,
    input  logic [NUM_CH*WIDTH-1:0] cfg_duty,
    input  logic [NUM_CH-1:0]       cfg_polarity,
    input  logic                    cfg_center,
`ifdef PWM_PHASE_OFFSET_EN
    input  logic [NUM_CH*WIDTH-1:0] cfg_phase,
`endif
    input  logic                    update_req,
    output logic                    update_ack,
    output logic                    end_of_period,
    output logic [WIDTH-1:0]        pwm_cnt,
    output logic [NUM_CH-1:0]       pwm_out
);
    localparam int unsigned DW = NUM_CH * WIDTH;
    localparam int unsigned SW = WIDTH + 1;

    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic [WIDTH-1:0]  per_q, per_d;
    logic [DW-1:0]     duty_q, duty_d;
    logic [NUM_CH-1:0] pol_q, pol_d;
    logic              center_q, center_d;
    logic              ack_q, ack_d;
    logic [NUM_CH-1:0] out_q, out_d;
`ifdef PWM_PHASE_OFFSET_EN
    logic [DW-1:0]     phase_q, phase_d;
    logic [WIDTH-1:0]  ph;
    logic [SW-1:0]     sum;
`endif
    logic              last_c;
    logic              commit_c;
    logic [WIDTH-1:0]  cnt_ch;
    logic              raw;

    // Last cycle of the current period (P==0 makes every cycle the last)
    always_comb begin
        last_c = 1'b0;
        if (per_q == '0) begin
            last_c = 1'b1;
        end else if (center_q) begin
            if (per_q == WIDTH'(1)) begin
                last_c = (cnt_q == WIDTH'(1));
            end else begin
                last_c = dir_q && (cnt_q == WIDTH'(1));
            end
        end else begin
            last_c = (cnt_q == per_q);
        end
    end

    assign end_of_period = enable & last_c;
    assign commit_c      = update_req & (~enable | last_c);

    // Counter sequencing and shadow-register commit
    always_comb begin
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        per_d    = per_q;
        duty_d   = duty_q;
        pol_d    = pol_q;
        center_d = center_q;
        ack_d    = commit_c;
`ifdef PWM_PHASE_OFFSET_EN
        phase_d  = phase_q;
`endif
        if (!enable || per_q == '0) begin
            cnt_d = '0;
            dir_d = 1'b0;
        end else if (!center_q) begin
            cnt_d = last_c ? '0 : cnt_q + WIDTH'(1);
        end else if (!dir_q) begin
            if (cnt_q == per_q) begin
                // P==1 has no down leg: wrap straight back to 0 while staying up
                cnt_d = per_q - WIDTH'(1);
                dir_d = (per_q != WIDTH'(1));
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else if (cnt_q == WIDTH'(1)) begin
            cnt_d = '0;
            dir_d = 1'b0;
        end else begin
            cnt_d = cnt_q - WIDTH'(1);
        end

        if (commit_c) begin
            cnt_d    = '0;
            dir_d    = 1'b0;
            per_d    = cfg_period;
            duty_d   = cfg_duty;
            pol_d    = cfg_polarity;
            center_d = cfg_center;
`ifdef PWM_PHASE_OFFSET_EN
            phase_d  = cfg_phase;
`endif
        end
    end

    // Per-channel compare; disabled channels park at their inactive level
    always_comb begin
        out_d  = '0;
        cnt_ch = '0;
        raw    = 1'b0;
`ifdef PWM_PHASE_OFFSET_EN
        ph     = '0;
        sum    = '0;
`endif
        for (int unsigned i = 0; i < NUM_CH; i++) begin
`ifdef PWM_PHASE_OFFSET_EN
            ph = phase_q[i*WIDTH +: WIDTH];
            if (center_q || ph > per_q) begin
                cnt_ch = cnt_q;
            end else begin
                sum = {1'b0, cnt_q} + {1'b0, ph};
                if (sum > {1'b0, per_q}) begin
                    sum = sum - ({1'b0, per_q} + SW'(1));
                end
                cnt_ch = sum[WIDTH-1:0];
            end
`else
            cnt_ch = cnt_q;
`endif
            raw      = (cnt_ch < duty_q[i*WIDTH +: WIDTH]);
            out_d[i] = enable ? (raw ^ pol_q[i]) : pol_q[i];
        end
    end

    always_ff @(posedge pwm_clk) begin
        if (rst) begin
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            per_q    <= '0;
            duty_q   <= '0;
            pol_q    <= '0;
            center_q <= 1'b0;
            ack_q    <= 1'b0;
            out_q    <= '0;
`ifdef PWM_PHASE_OFFSET_EN
            phase_q  <= '0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            per_q    <= per_d;
            duty_q   <= duty_d;
            pol_q    <= pol_d;
            center_q <= center_d;
            ack_q    <= ack_d;
            out_q    <= out_d;
`ifdef PWM_PHASE_OFFSET_EN
            phase_q  <= phase_d;
`endif
        end
    end

    assign update_ack = ack_q;
    assign pwm_cnt    = cnt_q;
    assign pwm_out    = out_q;

endmodule

// File: tb/tb_axi_pwm_custom_multi.sv
// Self-checking bench for axi_pwm_custom_multi: period-position reference model plus directed pins.
module tb_axi_pwm_custom_multi;
    localparam int NC = 4;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          rst, enable, cfg_center, update_req;
    logic [W-1:0]  cfg_period;
    logic [NC*W-1:0] cfg_duty;
    logic [NC-1:0] cfg_polarity;
`ifdef PWM_PHASE_OFFSET_EN
    logic [NC*W-1:0] cfg_phase;
`endif
    logic          update_ack, end_of_period;
    logic [W-1:0]  pwm_cnt;
    logic [NC-1:0] pwm_out;

    always #5 clk = ~clk;

    axi_pwm_custom_multi #(.NUM_CH(NC), .WIDTH(W)) dut (
        .pwm_clk(clk), .rst(rst), .enable(enable), .cfg_period(cfg_period),
        .cfg_duty(cfg_duty), .cfg_polarity(cfg_polarity), .cfg_center(cfg_center),
`ifdef PWM_PHASE_OFFSET_EN
        .cfg_phase(cfg_phase),
`endif
        .update_req(update_req), .update_ack(update_ack), .end_of_period(end_of_period),
        .pwm_cnt(pwm_cnt), .pwm_out(pwm_out)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Reference model: position k within the period, period length from the mode rules
    int          m_k, m_per;
    int          m_duty[NC];
    bit [NC-1:0] m_pol, m_out;
    bit          m_center, m_ack;
`ifdef PWM_PHASE_OFFSET_EN
    int          m_phase[NC];
`endif

    function automatic int m_len();
        if (m_center) return (m_per == 0) ? 1 : 2 * m_per;
        return m_per + 1;
    endfunction

    function automatic int m_cnt();
        if (!m_center || m_k <= m_per) return m_k;
        return 2 * m_per - m_k;
    endfunction

    function automatic bit m_last();
        return m_k == m_len() - 1;
    endfunction

    function automatic int m_ch_cnt(int i);
        int c;
        c = m_cnt();
`ifdef PWM_PHASE_OFFSET_EN
        if (!m_center && m_phase[i] <= m_per) c = (c + m_phase[i]) % (m_per + 1);
`endif
        return c;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit          commit;
        bit [NC-1:0] nxt;
        if (rst) begin
            m_k = 0; m_per = 0; m_pol = '0; m_out = '0; m_center = 0; m_ack = 0;
            for (int i = 0; i < NC; i++) begin
                m_duty[i] = 0;
`ifdef PWM_PHASE_OFFSET_EN
                m_phase[i] = 0;
`endif
            end
        end else begin
            commit = update_req && (!enable || m_last());
            for (int i = 0; i < NC; i++)
                nxt[i] = enable ? ((m_ch_cnt(i) < m_duty[i]) ^ m_pol[i]) : m_pol[i];
            m_out = nxt;
            m_k   = enable ? (m_k + 1) % m_len() : 0;
            m_ack = commit;
            if (commit) begin
                m_k = 0; m_per = int'(cfg_period); m_pol = cfg_polarity; m_center = cfg_center;
                for (int i = 0; i < NC; i++) begin
                    m_duty[i] = int'(cfg_duty[i*W +: W]);
`ifdef PWM_PHASE_OFFSET_EN
                    m_phase[i] = int'(cfg_phase[i*W +: W]);
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pwm_cnt", 32'(pwm_cnt), 32'(m_cnt()));
            check("pwm_out", 32'(pwm_out), 32'(m_out));
            check("update_ack", 32'(update_ack), 32'(m_ack));
            check("end_of_period", 32'(end_of_period), 32'(enable && m_last()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string nm);
        int t;
        t = 0;
        while (update_ack !== 1'b1 && t < 300) begin
            tick();
            t++;
        end
        if (update_ack !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: update_ack never seen within %0d cycles", nm, t);
        end
        update_req = 1'b0;
    endtask

    function automatic logic [NC*W-1:0] pack4(int d0, int d1, int d2, int d3);
        return {W'(d3), W'(d2), W'(d1), W'(d0)};
    endfunction

    task automatic request(input int per, input logic [NC*W-1:0] duty,
                           input logic [NC-1:0] pol, input bit center);
        cfg_period   = W'(per);
        cfg_duty     = duty;
        cfg_polarity = pol;
        cfg_center   = center;
        update_req   = 1'b1;
    endtask

    int hi_cnt[NC];
    int eop_cnt;

    task automatic count_win(input int n);
        eop_cnt = 0;
        for (int i = 0; i < NC; i++) hi_cnt[i] = 0;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < NC; i++) hi_cnt[i] += int'(pwm_out[i]);
            eop_cnt += int'(end_of_period);
            tick();
        end
    endtask

    initial begin
        int exp_seq[8];
        rst = 1'b1; enable = 1'b0; update_req = 1'b0; cfg_center = 1'b0;
        cfg_period = '0; cfg_duty = '0; cfg_polarity = '0;
`ifdef PWM_PHASE_OFFSET_EN
        cfg_phase = '0;
`endif
        tick();
        chk_en = 1;
        repeat (2) tick();
        check("rst_cnt", 32'(pwm_cnt), 0);
        check("rst_out", 32'(pwm_out), 0);
        check("rst_ack", 32'(update_ack), 0);

        rst = 1'b0; enable = 1'b1;
        repeat (3) tick();
        check("idle_eop", 32'(end_of_period), 1);
        check("idle_out", 32'(pwm_out), 0);

        // Edge mode, P=9, duty {0,3,10,255}
        request(9, pack4(0, 3, 10, 255), 4'b0000, 1'b0);
        wait_ack("ack_edge");
        tick();
        check("ack_pulse", 32'(update_ack), 0);
        count_win(10);
        check("edge_ch0_hi", 32'(hi_cnt[0]), 0);
        check("edge_ch1_hi", 32'(hi_cnt[1]), 3);
        check("edge_ch2_hi", 32'(hi_cnt[2]), 10);
        check("edge_ch3_hi", 32'(hi_cnt[3]), 10);
        check("edge_eops", 32'(eop_cnt), 1);

        // Inverted ch1
        request(9, pack4(0, 3, 10, 255), 4'b0010, 1'b0);
        wait_ack("ack_pol");
        repeat (2) tick();
        count_win(10);
        check("pol_ch1_hi", 32'(hi_cnt[1]), 7);
        enable = 1'b0;
        tick();
        check("dis_out", 32'(pwm_out), 32'(4'b0010));
        check("dis_cnt", 32'(pwm_cnt), 0);
        check("dis_eop", 32'(end_of_period), 0);
        enable = 1'b1;
        repeat (3) tick();

        // Center mode, P=4
        request(4, pack4(1, 2, 5, 0), 4'b0000, 1'b1);
        wait_ack("ack_center");
        exp_seq = '{0, 1, 2, 3, 4, 3, 2, 1};
        for (int j = 0; j < 8; j++) begin
            check("center_seq", 32'(pwm_cnt), 32'(exp_seq[j]));
            tick();
        end
        count_win(8);
        check("center_ch1_hi", 32'(hi_cnt[1]), 3);
        check("center_eops", 32'(eop_cnt), 1);

        // Request raised mid-period waits for the boundary
        begin
            int t;
            t = 0;
            while (pwm_cnt != W'(2) && t < 50) begin tick(); t++; end
        end
        request(4, pack4(4, 4, 4, 4), 4'b0000, 1'b1);
        tick();
        check("mid_no_ack", 32'(update_ack), 0);
        wait_ack("ack_mid");
        check("mid_cnt0", 32'(pwm_cnt), 0);
        repeat (10) tick();

        // Reset while a request is pending
        request(200, pack4(50, 60, 70, 80), 4'b1111, 1'b0);
        wait_ack("ack_long");
        repeat (3) tick();
        request(100, pack4(1, 1, 1, 1), 4'b0101, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        update_req = 1'b0;
        check("rstpend_ack", 32'(update_ack), 0);
        check("rstpend_out", 32'(pwm_out), 0);
        check("rstpend_cnt", 32'(pwm_cnt), 0);
        tick();
        rst = 1'b0;
        tick();
        check("rstpend_eop", 32'(end_of_period), 1);

`ifdef PWM_PHASE_OFFSET_EN
        begin
            bit s0[20], s1[20];
            cfg_phase = pack4(0, 5, 0, 0);
            request(9, pack4(5, 5, 5, 5), 4'b0000, 1'b0);
            wait_ack("ack_phase");
            repeat (2) tick();
            for (int t = 0; t < 20; t++) begin
                s0[t] = pwm_out[0];
                s1[t] = pwm_out[1];
                tick();
            end
            for (int t = 5; t < 20; t++) check("phase_shift", 32'(s1[t]), 32'(s0[t-5]));
        end
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst    = ($urandom_range(0, 499) == 0);
            enable = ($urandom_range(0, 15) != 0);
            if (update_ack) begin
                update_req = 1'b0;
            end else if (!update_req && $urandom_range(0, 7) == 0) begin
                cfg_period   = W'($urandom_range(0, 12));
                for (int i = 0; i < NC; i++)
                    cfg_duty[i*W +: W] = ($urandom_range(0, 7) == 0) ? W'(255) : W'($urandom_range(0, 14));
                cfg_polarity = NC'($urandom);
                cfg_center   = 1'($urandom);
`ifdef PWM_PHASE_OFFSET_EN
                for (int i = 0; i < NC; i++) cfg_phase[i*W +: W] = W'($urandom_range(0, 15));
`endif
                update_req = 1'b1;
            end
            tick();
        end
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
